prog_loader: RTL and testbench

Program-memory loader that drives the 12-bit instruction memory's load port (load enable, load address, load instruction) from a byte-wide valid/ready stream. It receives a word count followed by two bytes per instruction, assembles each 12-bit instruction, and writes them to consecutive addresses starting at 0. While a load is in progress it holds the CPU, so the fetch side never reads a partially loaded program.

---
 rtl/prog_loader.sv | 140 ++++++++++++++
 tb/tb_prog_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles 12-bit instructions and writes them to program memory from address 0.
// Optional trailing XOR checksum byte is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        LE,
  output logic [7:0]  LA,
  output logic [11:0] LI,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_CNT,
    S_GET_HI,
    S_GET_LO,
    S_WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_DONE,
    S_GET_CHK
`else
    S_DONE
`endif
  } state_t;

  state_t      state, state_n;
  logic [7:0]  addr;
  logic [8:0]  remaining;
  logic [3:0]  hi;
  logic        accept;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]  chk;
  logic        err_r;
  assign err      = err_r;
  assign in_ready = (state == S_GET_CNT) || (state == S_GET_HI) ||
                    (state == S_GET_LO)  || (state == S_GET_CHK);
`else
  assign err      = 1'b0;
  assign in_ready = (state == S_GET_CNT) || (state == S_GET_HI) ||
                    (state == S_GET_LO);
`endif

  assign accept = in_valid && in_ready;
  assign LE     = (state == S_WRITE);
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (start)  state_n = S_GET_CNT;
      S_GET_CNT: if (accept) state_n = S_GET_HI;
      S_GET_HI:  if (accept) state_n = S_GET_LO;
      S_GET_LO:  if (accept) state_n = S_WRITE;
      S_WRITE: begin
        // remaining still holds the pre-decrement value here
        if (remaining == 9'd1) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_n = S_GET_CHK;
`else
          state_n = S_DONE;
`endif
        end else begin
          state_n = S_GET_HI;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_GET_CHK: if (accept) state_n = S_DONE;
`endif
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= 8'd0;
      remaining <= 9'd0;
      hi        <= 4'd0;
      LA        <= 8'd0;
      LI        <= 12'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
      chk       <= 8'd0;
      err_r     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            addr <= 8'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk   <= 8'd0;
            err_r <= 1'b0;
`endif
          end
        end
        // a count byte of zero encodes a full 256-word load
        S_GET_CNT: if (accept) remaining <= {(in_data == 8'd0), in_data};
        S_GET_HI: begin
          if (accept) begin
            hi <= in_data[3:0];
`ifdef PROG_LOADER_CHECKSUM_EN
            chk <= chk ^ in_data;
`endif
          end
        end
        S_GET_LO: begin
          if (accept) begin
            LI <= {hi, in_data};
            LA <= addr;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk <= chk ^ in_data;
`endif
          end
        end
        S_WRITE: begin
          addr      <= addr + 8'd1;
          remaining <= remaining - 9'd1;
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        S_GET_CHK: if (accept && (in_data != chk)) err_r <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: expected writes are derived from the byte stream itself.
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready, LE, busy, done, err;
  logic [7:0]  LA;
  logic [11:0] LI;

  int checks = 0;
  int failures = 0;
  int le_count = 0;
  int done_count = 0;
  int loads = 0;
  bit armed = 1'b0;

  logic [7:0]  stream[$];
  logic [19:0] exp_q[$];
  logic [19:0] wlog[$];
  logic [19:0] last_w = 20'd0;

  prog_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .LE(LE), .LA(LA), .LI(LI), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Reset discards any words not yet written.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      last_w = 20'd0;
      armed = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      if (LE) begin
        le_count++;
        wlog.push_back({LA, LI});
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_LE: got LA/LI 0x%0h expected no write", {LA, LI});
        end else begin
          check("write_LA_LI", 32'({LA, LI}), 32'(exp_q.pop_front()));
        end
        last_w = {LA, LI};
      end else begin
        check("hold_LA_LI", 32'({LA, LI}), 32'(last_w));
      end
      if (done) done_count++;
`ifndef PROG_LOADER_CHECKSUM_EN
      check("err_tied_low", 32'(err), 32'd0);
`endif
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int guard;
    in_valid = 1'b1;
    in_data  = b;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_load(input int gap_max, input bit mid_start, input bit chk_good);
    int n, waitc, le0, g;
    logic [7:0] x;
    n = (stream[0] == 8'd0) ? 256 : int'(stream[0]);
    x = 8'd0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({8'(i), stream[1 + 2 * i][3:0], stream[2 + 2 * i]});
      x = x ^ stream[1 + 2 * i] ^ stream[2 + 2 * i];
    end
    le0 = le_count;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("ready_after_start", 32'(in_ready), 32'd1);
    check("err_after_start", 32'(err), 32'd0);
    for (int i = 0; i <= 2 * n; i++) begin
      if (gap_max > 0) begin
        g = $urandom_range(gap_max, 0);
        repeat (g) begin @(posedge clk); #1; end
      end
      if (mid_start && i == 3) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      send_byte(stream[i]);
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(chk_good ? x : ~x);
`endif
    waitc = 0;
    while (!done && waitc < 8) begin
      @(posedge clk); #1;
      waitc++;
    end
    check("done_seen", 32'(done), 32'd1);
`ifdef PROG_LOADER_CHECKSUM_EN
    check("done_latency", 32'(waitc), 32'd0);
    check("err_at_done", 32'(err), 32'(!chk_good));
`else
    check("done_latency", 32'(waitc), 32'd1);
`endif
    check("busy_during_done", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_single", 32'(done), 32'd0);
    check("le_pulses", 32'(le_count - le0), 32'(n));
    loads++;
  endtask

  initial begin
    int base;
    // reset with random inputs
    repeat (2) begin
      start = 1'($urandom);
      in_valid = 1'($urandom);
      in_data = 8'($urandom);
      @(posedge clk); #1;
    end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    check("rst_LE", 32'(LE), 32'd0);
    check("rst_LA", 32'(LA), 32'd0);
    check("rst_LI", 32'(LI), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;

    // basic load
    stream = '{8'h02, 8'h0A, 8'hBC, 8'h01, 8'h23};
    base = wlog.size();
    do_load(0, 1'b0, 1'b1);
    check("basic_w0", 32'(wlog[base]), 32'h00ABC);
    check("basic_w1", 32'(wlog[base + 1]), 32'h01123);

    // upper nibble of HI byte ignored
    stream = '{8'h02, 8'hFA, 8'hBC, 8'h01, 8'h23};
    base = wlog.size();
    do_load(0, 1'b0, 1'b1);
    check("nibble_w0", 32'(wlog[base]), 32'h00ABC);

    // gaps plus a mid-load start
    stream = '{8'h02, 8'h0A, 8'hBC, 8'h01, 8'h23};
    base = wlog.size();
    do_load(3, 1'b1, 1'b1);
    check("gaps_w1", 32'(wlog[base + 1]), 32'h01123);

    // full 256-word load
    stream.delete();
    stream.push_back(8'h00);
    for (int i = 0; i < 512; i++) stream.push_back(8'($urandom));
    base = wlog.size();
    do_load(0, 1'b0, 1'b1);
    check("full_last_LA", 32'(wlog[base + 255][19:12]), 32'hFF);

    // reset one cycle after the first write
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_q.push_back(20'h00111);
    exp_q.push_back(20'h01222);
    exp_q.push_back(20'h02333);
    send_byte(8'h03);
    send_byte(8'h01);
    send_byte(8'h11);
    check("midrst_LE_pulse", 32'(LE), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_LE", 32'(LE), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd0);
    check("midrst_LA", 32'(LA), 32'd0);
    check("midrst_LI", 32'(LI), 32'd0);
    stream = '{8'h01, 8'h05, 8'h67};
    base = wlog.size();
    do_load(0, 1'b0, 1'b1);
    check("after_rst_w0", 32'(wlog[base]), 32'h00567);

`ifdef PROG_LOADER_CHECKSUM_EN
    stream = '{8'h01, 8'h0A, 8'hBC};
    do_load(0, 1'b0, 1'b1);
    check("chk_good_err", 32'(err), 32'd0);
    do_load(0, 1'b0, 1'b0);
    check("chk_bad_sticky", 32'(err), 32'd1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("chk_cleared_by_start", 32'(err), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
`endif

    check("done_pulses", 32'(done_count), 32'(loads));
    check("no_pending_writes", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
